// File: rtl/pe_command_sequencer_if.sv
// pe_command_sequencer_if
//   Boundary bus between the command sequencer and the message_passer PE array.
//   Ports / signals:
//     pe_ready            AND of all PE ready outputs (array -> sequencer)
//     pe_ack              ack to all PEs (sequencer -> array)
//     command_to_execute  3-bit command to the PEs
//     isu/isl/isd/isr     edge-lane data to the array boundary, PRECISION bits each
//   Modports: master = sequencer side, slave = PE array side.
interface pe_command_sequencer_if #(
    parameter int unsigned PRECISION = 8
);
    logic                 pe_ready;
    logic                 pe_ack;
    logic [2:0]           command_to_execute;
    logic [PRECISION-1:0] isu;
    logic [PRECISION-1:0] isl;
    logic [PRECISION-1:0] isd;
    logic [PRECISION-1:0] isr;

    modport master (
        input  pe_ready,
        output pe_ack,
        output command_to_execute,
        output isu,
        output isl,
        output isd,
        output isr
    );

    modport slave (
        output pe_ready,
        input  pe_ack,
        input  command_to_execute,
        input  isu,
        input  isl,
        input  isd,
        input  isr
    );
endinterface

// File: rtl/pe_command_sequencer.sv
// pe_command_sequencer
//   Upstream feeder for a message_passer PE chain/mesh. Host (command, edge-data)
//   words are buffered in a DEPTH-entry FIFO and issued one at a time to the
//   PEs with the ack/ready handshake. NOP words (cmd 000) are dropped unissued.
//   Completed non-NOP operations are counted in ops_done (wrapping).
//
//   Optional feature macro: SEQ_TIMEOUT_EN
//     defined   - watchdog over REQ/EXEC; after TIMEOUT_CYCLES the op is dropped,
//                 the FSM returns to IDLE and the sticky timeout flag is set.
//     undefined - no watchdog, the FSM waits indefinitely, timeout is 0.
//
//   Ports:
//     CLK, RSTN    clock (rising edge), asynchronous active-low reset
//     in_valid     host word valid
//     in_ready     FIFO not full (registered state only)
//     in_cmd       3-bit command code
//     in_data      edge lanes {r,d,l,u}, u in the LSBs
//     pe           PE boundary bus (master modport)
//     busy         FSM not idle or FIFO not empty
//     ops_done     completed non-NOP op count
//     fifo_level   current FIFO occupancy
//     timeout      sticky watchdog flag
module pe_command_sequencer #(
    parameter int unsigned PRECISION      = 8,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_cmd,
    input  logic [4*PRECISION-1:0]   in_data,
    pe_command_sequencer_if.master   pe,
    output logic                     busy,
    output logic [CNT_W-1:0]         ops_done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = 4 * PRECISION;
    localparam int unsigned WW = 3 + DW;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        EXEC
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [WW-1:0] head;
    logic [2:0]    head_cmd;
    logic [DW-1:0] head_data;

    // Fullness is taken from the registered count only, so a push is refused
    // while full even if a pop happens in the same cycle.
    assign full      = (count == LW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = in_valid && !full;
    assign head      = mem[rd_ptr];
    assign head_cmd  = head[WW-1 -: 3];
    assign head_data = head[DW-1:0];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {in_cmd, in_data};
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic              start;   // non-NOP popped, enter REQ
    logic              launch;  // PEs dropped ready, drive the command
    logic              finish;  // PEs raised ready, op complete
    logic              expire;  // watchdog fired
    logic              wd_hit;

    logic [2:0]        hold_cmd;
    logic [DW-1:0]     hold_data;
    logic              ack_q;
    logic [2:0]        cmd_q;
    logic [DW-1:0]     lanes_q;
    logic [CNT_W-1:0]  ops_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        start   = 1'b0;
        launch  = 1'b0;
        finish  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_cmd != 3'b000) begin
                        start   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (wd_hit) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end else if (!pe.pe_ready) begin
                    launch  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (wd_hit) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end else if (pe.pe_ready) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            hold_cmd  <= '0;
            hold_data <= '0;
            ack_q     <= 1'b0;
            cmd_q     <= '0;
            lanes_q   <= '0;
            ops_q     <= '0;
        end else begin
            if (pop) begin
                hold_cmd  <= head_cmd;
                hold_data <= head_data;
            end
            if (start) begin
                ack_q <= 1'b1;
            end else if (launch || expire) begin
                ack_q <= 1'b0;
            end
            // Lanes are only reloaded on issue; they keep their value after
            // completion so the array boundary stays stable between ops.
            if (launch) begin
                cmd_q   <= hold_cmd;
                lanes_q <= hold_data;
            end else if (finish || expire) begin
                cmd_q <= '0;
            end
            if (finish) begin
                ops_q <= ops_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt;
    logic          timeout_q;

    // Counter restarts on entry to REQ and to EXEC; the cycle in which it
    // equals the limit is the last one spent waiting.
    assign wd_hit = (state_q != IDLE) && (wd_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start || launch) begin
                wd_cnt <= '0;
            end else if ((state_q != IDLE) && !wd_hit) begin
                wd_cnt <= wd_cnt + TW'(1);
            end
            if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready              = !full;
    assign fifo_level            = count;
    assign busy                  = (state_q != IDLE) || !empty;
    assign ops_done              = ops_q;
    assign pe.pe_ack             = ack_q;
    assign pe.command_to_execute = cmd_q;
    assign pe.isu                = lanes_q[0*PRECISION +: PRECISION];
    assign pe.isl                = lanes_q[1*PRECISION +: PRECISION];
    assign pe.isd                = lanes_q[2*PRECISION +: PRECISION];
    assign pe.isr                = lanes_q[3*PRECISION +: PRECISION];

endmodule

// File: tb/tb_pe_command_sequencer.sv
// tb_pe_command_sequencer
//   Self-checking bench for pe_command_sequencer. A queue-based reference model
//   predicts every output each cycle; directed table vectors and hand-written
//   sequences cover handshake, NOP drop, full-FIFO refusal, mid-op reset,
//   counter wrap and (with SEQ_TIMEOUT_EN) the watchdog.
module tb_pe_command_sequencer;

    localparam int unsigned PRECISION      = 8;
    localparam int unsigned DEPTH          = 8;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned TIMEOUT_CYCLES = 10;
`ifdef SEQ_TIMEOUT_EN
    localparam bit HAS_TO = 1'b1;
`else
    localparam bit HAS_TO = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] data;
    } word_t;

    typedef enum int {M_IDLE, M_REQ, M_EXEC} mphase_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] data;
        logic [7:0]  u;
        logic [7:0]  l;
        logic [7:0]  d;
        logic [7:0]  r;
        int unsigned inc;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_cmd = '0;
    logic [31:0] in_data = '0;
    logic        busy;
    logic [CNT_W-1:0] ops_done;
    logic [3:0]  fifo_level;
    logic        timeout;
    logic        pe_ready = 1'b1;

    always #5 CLK = ~CLK;

    pe_command_sequencer_if #(.PRECISION(PRECISION)) pe_bus ();
    assign pe_bus.pe_ready = pe_ready;

    pe_command_sequencer #(
        .PRECISION(PRECISION),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_cmd(in_cmd),
        .in_data(in_data),
        .pe(pe_bus),
        .busy(busy),
        .ops_done(ops_done),
        .fifo_level(fifo_level),
        .timeout(timeout)
    );

    // Reference model state
    word_t       m_q[$];
    mphase_t     m_phase;
    word_t       m_hold;
    logic        m_ack;
    logic [2:0]  m_cmd;
    logic [31:0] m_lanes;
    int unsigned m_ops;
    int unsigned m_wd;
    logic        m_to;

    int vectors = 0;
    int miscompares = 0;
    int acks = 0;
    logic prev_ack = 1'b0;
    int pe_mode = 0;   // 0 = responsive PE, 1 = ready stuck high, 2 = random ready
    int lo_cnt = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = M_IDLE;
        m_hold  = '0;
        m_ack   = 1'b0;
        m_cmd   = '0;
        m_lanes = '0;
        m_ops   = 0;
        m_wd    = 0;
        m_to    = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_next();
        int    pre;
        bit    do_push;
        word_t w;
        pre     = m_q.size();
        do_push = in_valid && (pre < DEPTH);
        case (m_phase)
            M_IDLE: begin
                if (pre > 0) begin
                    w = m_q.pop_front();
                    if (w.cmd != 3'b000) begin
                        m_hold  = w;
                        m_phase = M_REQ;
                        m_ack   = 1'b1;
                        m_wd    = 0;
                    end
                end
            end
            M_REQ: begin
                if (HAS_TO && m_wd == TIMEOUT_CYCLES) begin
                    m_to = 1'b1; m_ack = 1'b0; m_cmd = '0; m_phase = M_IDLE;
                end else if (!pe_ready) begin
                    m_cmd = m_hold.cmd; m_lanes = m_hold.data; m_ack = 1'b0;
                    m_phase = M_EXEC; m_wd = 0;
                end else begin
                    m_wd++;
                end
            end
            M_EXEC: begin
                if (HAS_TO && m_wd == TIMEOUT_CYCLES) begin
                    m_to = 1'b1; m_ack = 1'b0; m_cmd = '0; m_phase = M_IDLE;
                end else if (pe_ready) begin
                    m_cmd = '0; m_ops = (m_ops + 1) % (1 << CNT_W); m_phase = M_IDLE;
                end else begin
                    m_wd++;
                end
            end
            default: m_phase = M_IDLE;
        endcase
        if (do_push) begin
            m_q.push_back({in_cmd, in_data});
        end
    endtask

    task automatic check_all();
        cmp("in_ready",   in_ready,   (m_q.size() < DEPTH));
        cmp("fifo_level", fifo_level, m_q.size());
        cmp("busy",       busy,       (m_phase != M_IDLE) || (m_q.size() != 0));
        cmp("pe_ack",     pe_bus.pe_ack, m_ack);
        cmp("command",    pe_bus.command_to_execute, m_cmd);
        cmp("isu",        pe_bus.isu, m_lanes[7:0]);
        cmp("isl",        pe_bus.isl, m_lanes[15:8]);
        cmp("isd",        pe_bus.isd, m_lanes[23:16]);
        cmp("isr",        pe_bus.isr, m_lanes[31:24]);
        cmp("ops_done",   ops_done,   m_ops);
        cmp("timeout",    timeout,    m_to);
    endtask

    // One clock: model predicts, DUT clocks, outputs checked at the falling edge,
    // then the PE model reacts and the push strobe is dropped.
    task automatic step();
        model_next();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
        if (pe_bus.pe_ack && !prev_ack) acks++;
        prev_ack = pe_bus.pe_ack;
        if (pe_mode == 0) begin
            if (pe_bus.pe_ack) begin
                pe_ready = 1'b0;
                lo_cnt   = 0;
            end else if (!pe_ready) begin
                lo_cnt++;
                if (lo_cnt >= 2) pe_ready = 1'b1;
            end
        end else if (pe_mode == 1) begin
            pe_ready = 1'b1;
        end else begin
            pe_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] d);
        for (int i = 0; i < 400 && m_q.size() >= DEPTH; i++) step();
        in_cmd   = c;
        in_data  = d;
        in_valid = 1'b1;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (m_phase != M_IDLE || m_q.size() != 0); i++) step();
        step();
        cmp("drain_busy", busy, 1'b0);
    endtask

    vec_t        tbl[6];
    int unsigned exp_ops;
    int          acks0;

    initial begin
        tbl[0] = '{3'b000, 32'hDEADBEEF, 8'h69, 8'h00, 8'h00, 8'h00, 0};
        tbl[1] = '{3'b010, 32'h0000A500, 8'h00, 8'hA5, 8'h00, 8'h00, 1};
        tbl[2] = '{3'b000, 32'h12345678, 8'h00, 8'hA5, 8'h00, 8'h00, 0};
        tbl[3] = '{3'b111, 32'h11223344, 8'h44, 8'h33, 8'h22, 8'h11, 1};
        tbl[4] = '{3'b101, 32'hFF000000, 8'h00, 8'h00, 8'h00, 8'hFF, 1};
        tbl[5] = '{3'b000, 32'h00000000, 8'h00, 8'h00, 8'h00, 8'hFF, 0};

        // Reset state
        model_reset();
        #12;
        check_all();
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;

        // Four identical ops through a responsive PE
        pe_mode = 0;
        acks = 0;
        for (int i = 0; i < 4; i++) push(3'b001, 32'h00000069);
        drain();
        cmp("a_ops",  ops_done, 4);
        cmp("a_isu",  pe_bus.isu, 8'h69);
        cmp("a_cmd",  pe_bus.command_to_execute, 3'b000);
        cmp("a_acks", acks, 4);
        cmp("a_busy", busy, 1'b0);
        exp_ops = 4;

        // Table-driven single ops
        for (int i = 0; i < 6; i++) begin
            push(tbl[i].cmd, tbl[i].data);
            drain();
            exp_ops = exp_ops + tbl[i].inc;
            cmp("tbl_isu", pe_bus.isu, tbl[i].u);
            cmp("tbl_isl", pe_bus.isl, tbl[i].l);
            cmp("tbl_isd", pe_bus.isd, tbl[i].d);
            cmp("tbl_isr", pe_bus.isr, tbl[i].r);
            cmp("tbl_ops", ops_done, exp_ops % 16);
        end

        // NOP, real op, NOP back-to-back: single handshake
        acks0 = acks;
        push(3'b000, 32'hFFFFFFFF);
        push(3'b010, 32'h0000A500);
        push(3'b000, 32'h01010101);
        drain();
        exp_ops = exp_ops + 1;
        cmp("nop_acks",  acks - acks0, 1);
        cmp("nop_isl",   pe_bus.isl, 8'hA5);
        cmp("nop_ops",   ops_done, exp_ops % 16);
        cmp("nop_level", fifo_level, 0);

        // PE never responds: fill the FIFO, tenth word refused
        pe_mode  = 1;
        pe_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_cmd   = 3'b011;
            in_data  = $urandom;
            in_valid = 1'b1;
            step();
        end
        cmp("full_ready", in_ready, 1'b0);
        cmp("full_level", fifo_level, 8);
        cmp("full_ops",   ops_done, exp_ops % 16);
        for (int i = 0; i < 3; i++) step();
        if (HAS_TO) begin
            cmp("to_flag", timeout, 1'b1);
            cmp("to_ack",  pe_bus.pe_ack, 1'b0);
            exp_ops = exp_ops + 8;
        end else begin
            cmp("to_flag", timeout, 1'b0);
            cmp("to_ack",  pe_bus.pe_ack, 1'b1);
            exp_ops = exp_ops + 9;
        end
        cmp("to_ops", ops_done, (exp_ops - (HAS_TO ? 8 : 9)) % 16);
        pe_mode = 0;
        drain();
        cmp("full_drain_ops", ops_done, exp_ops % 16);
        cmp("to_sticky", timeout, HAS_TO);

        // Reset during EXEC with three words buffered
        for (int i = 0; i < 4; i++) push(3'b001, $urandom);
        for (int i = 0; i < 20 && !(m_phase == M_EXEC && m_q.size() == 3); i++) step();
        cmp("rst_pre_level", fifo_level, 3);
        #2;
        RSTN = 1'b0;
        #1;
        model_reset();
        check_all();
        cmp("rst_level", fifo_level, 0);
        cmp("rst_ops",   ops_done, 0);
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        acks0 = acks;
        for (int i = 0; i < 10; i++) step();
        cmp("rst_no_hs", acks - acks0, 0);

        // Counter wrap: 17 ops on a 4-bit counter
        for (int i = 0; i < 17; i++) push(3'($urandom_range(1, 7)), $urandom);
        drain();
        cmp("wrap_ops", ops_done, 1);

        // Random traffic with random PE ready
        pe_mode = 2;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_cmd   = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            in_data  = $urandom;
            step();
        end
        pe_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_command_sequencer.md
Name: pe_command_sequencer

Overview:
Upstream feeder for a chain or mesh of message_passer processing elements (PEs). Buffers host-issued (command, edge-data) words in a small FIFO and issues them one at a time to the PEs using the ack/ready handshake. Drives command_to_execute and the four edge-lane inputs (isu, isl, isd, isr) of the array boundary. Counts completed operations for the host.

Parameters:
PRECISION, 8, width of each edge data lane.
DEPTH, 8, FIFO depth in words; power of two, 2 or more.
CNT_W, 16, width of the ops_done counter.
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with SEQ_TIMEOUT_EN).

Ports:
CLK  in  1  system clock, rising edge
RSTN  in  1  asynchronous active-low reset
in_valid  in  1  host word valid
in_ready  out  1  FIFO can accept a word; equals !full, registered state only
in_cmd  in  3  command code (000 = NOP, others passed to PEs)
in_data  in  4*PRECISION  edge lanes {r,d,l,u}; u in the LSBs
pe_ready  in  1  AND of all PE ready outputs
pe_ack  out  1  ack to all PEs
command_to_execute  out  3  command to PEs
isu/isl/isd/isr  out  PRECISION each  edge lane data to the array boundary
busy  out  1  FSM not in IDLE, or FIFO not empty
ops_done  out  CNT_W  number of completed non-NOP ops; wraps
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, sync release): FIFO empty; pe_ack=0; command_to_execute=000; all edge lanes 0; ops_done=0; timeout=0; FSM=IDLE; in_ready=1.
- FIFO:
  - Write on in_valid && in_ready.
  - No fall-through: a word written into an empty FIFO is poppable on the next cycle.
  - Push while full is refused. This holds even when a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, REQ, EXEC:
  - IDLE, FIFO not empty: pop the head into holding registers.
    - If cmd=000: discard it, stay in IDLE, do not count it.
    - Otherwise: go to REQ and set pe_ack=1 (registered, visible the next cycle).
  - REQ: hold pe_ack=1. When pe_ready is sampled 0, load command_to_execute and the four lanes from the holding registers, set pe_ack=0, and go to EXEC.
  - EXEC: hold the command. When pe_ready is sampled 1:
    - command_to_execute returns to 000 the next cycle.
    - ops_done increments by 1.
    - Go to IDLE.
    - Edge lanes keep their values until the next issue.
  - Minimum of 3 cycles per op (IDLE, REQ, EXEC), plus PE latency.
- pe_ready is treated as synchronous to CLK; no internal synchronizer.
- ops_done wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: immediate return to the reset values above. In-flight and buffered words are lost.

Optional Feature:
SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in REQ and EXEC and clears on entry to either state. If the counter reaches TIMEOUT_CYCLES, then on the next cycle:
  - timeout=1 (sticky until reset);
  - pe_ack=0 and command_to_execute=000;
  - the op is discarded and not counted;
  - FSM goes to IDLE.
- Not defined: no counter; the FSM waits indefinitely; timeout is tied to 0.

Test Plan:
- PE model (ready drops 1 cycle after ack=1, rises 2 cycles after ack=0). Push 4 words cmd=001, u-lane=0x69 -> ops_done=4; isu=0x69 held; command_to_execute=000 at end; pe_ack pulses exactly 4 times; busy=0.
- pe_ready held at 1 (PE never responds). Push 10 words back-to-back -> one word goes to the holding register, 8 are accepted into the FIFO, then in_ready=0 and fifo_level=8. The 10th word is refused; ops_done stays 0.
- Push NOP, cmd=010 with l-lane=0xA5, NOP -> only one handshake occurs; isl=0xA5; ops_done=1; FIFO ends empty.
- Assert RSTN=0 during EXEC with 3 words buffered -> outputs are at reset values in the same cycle; fifo_level=0, ops_done=0. After release, no handshake occurs until a new push.
- Preload ops_done near the limit (CNT_W=4, 17 ops) -> ops_done=1 after wrap.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, pe_ready stuck at 1 -> timeout=1 after 11 cycles in REQ; pe_ack=0; ops_done unchanged. The next word is processed normally and timeout stays 1.
